mux_n_to_1_pipe: RTL and testbench

- Parametrised N-input, W-bit selector with one registered output stage and a valid/ready handshake.
- Generalises the datapath 2:1 word mux into a pipelined N:1 mux for forwarding and writeback select paths, where a stage register is needed and downstream can stall.
- Contains a main output register plus a one-entry skid register, so in_ready is driven from a flop and never combinationally from out_ready.

---
 rtl/mux_n_to_1_pipe.sv | 147 ++++++++++++++
 tb/tb_mux_n_to_1_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_pipe.sv
// Pipelined N:1 word selector with a main output register, a one-entry skid register and a
// registered in_ready. Define MUX_PIPE_SEL_ERR_EN to add out_sel_err and the err_cnt counter.
module mux_n_to_1_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
`ifdef MUX_PIPE_SEL_ERR_EN
  output logic                    out_sel_err,
  output logic [7:0]              err_cnt,
`endif
  input  logic                    out_ready
);

  logic [WIDTH-1:0] sel_word;
  logic             in_xfer, out_xfer;

  logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;

`ifdef MUX_PIPE_SEL_ERR_EN
  logic       sel_oor;
  logic       main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign sel_oor = (32'(in_sel) >= NUM_IN);
`endif

  // Out-of-range selects fall through to zero.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid_q && out_ready;

  always_comb begin
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_valid_d = skid_valid_q;
`ifdef MUX_PIPE_SEL_ERR_EN
    main_err_d   = main_err_q;
    skid_err_d   = skid_err_q;
    err_cnt_d    = err_cnt_q;
`endif
    if (flush) begin
      // Only valid bits are cleared; data registers may keep stale contents.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (in_xfer) begin
        main_data_d  = sel_word;
        main_sel_d   = in_sel;
        main_valid_d = 1'b1;
`ifdef MUX_PIPE_SEL_ERR_EN
        main_err_d   = sel_oor;
`endif
      end
    end else if (!skid_valid_q) begin
      if (in_xfer && out_xfer) begin
        main_data_d = sel_word;
        main_sel_d  = in_sel;
`ifdef MUX_PIPE_SEL_ERR_EN
        main_err_d  = sel_oor;
`endif
      end else if (in_xfer) begin
        skid_data_d  = sel_word;
        skid_sel_d   = in_sel;
        skid_valid_d = 1'b1;
`ifdef MUX_PIPE_SEL_ERR_EN
        skid_err_d   = sel_oor;
`endif
      end else if (out_xfer) begin
        main_valid_d = 1'b0;
      end
    end else if (out_xfer) begin
      main_data_d  = skid_data_q;
      main_sel_d   = skid_sel_q;
      skid_valid_d = 1'b0;
`ifdef MUX_PIPE_SEL_ERR_EN
      main_err_d   = skid_err_q;
`endif
    end
`ifdef MUX_PIPE_SEL_ERR_EN
    if (in_xfer && !flush && sel_oor && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
`endif
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
`ifdef MUX_PIPE_SEL_ERR_EN
      main_err_q   <= 1'b0;
      skid_err_q   <= 1'b0;
      err_cnt_q    <= '0;
`endif
    end else begin
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
`ifdef MUX_PIPE_SEL_ERR_EN
      main_err_q   <= main_err_d;
      skid_err_q   <= skid_err_d;
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_valid = main_valid_q;
`ifdef MUX_PIPE_SEL_ERR_EN
  assign out_sel_err = main_valid_q && main_err_q;
  assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Scoreboard bench for mux_n_to_1_pipe: a 4-input and a 3-input instance share one stimulus
// stream; the driver pushes expected entries and a negedge monitor pops and compares.
module tb_mux_n_to_1_pipe;

  logic        Clk = 1'b0;
  logic        Reset, in_valid, flush, out_ready;
  logic [1:0]  in_sel;
  logic [31:0] w [4];
  logic [127:0] in_data;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic [1:0]  out_sel_a, out_sel_b;
`ifdef MUX_PIPE_SEL_ERR_EN
  logic        out_sel_err_a, out_sel_err_b;
  logic [7:0]  err_cnt_a, err_cnt_b;
`endif

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic [1:0]  sel;
    logic        eb;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   err_m = 0;
  bit   mon_en = 1'b0;

  always #5 Clk = ~Clk;

  assign in_data = {w[3], w[2], w[1], w[0]};

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut_a (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready_a), .flush(flush), .out_data(out_data_a), .out_sel(out_sel_a),
    .out_valid(out_valid_a),
`ifdef MUX_PIPE_SEL_ERR_EN
    .out_sel_err(out_sel_err_a), .err_cnt(err_cnt_a),
`endif
    .out_ready(out_ready)
  );

  mux_n_to_1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .in_data(in_data[95:0]), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready_b), .flush(flush), .out_data(out_data_b), .out_sel(out_sel_b),
    .out_valid(out_valid_b),
`ifdef MUX_PIPE_SEL_ERR_EN
    .out_sel_err(out_sel_err_b), .err_cnt(err_cnt_b),
`endif
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUTs present against the head of the scoreboard.
  always @(negedge Clk) begin
    if (mon_en) begin
      chk("out_valid_a", 32'(out_valid_a), 32'(q.size() != 0));
      chk("out_valid_b", 32'(out_valid_b), 32'(q.size() != 0));
      chk("in_ready_a", 32'(in_ready_a), 32'(q.size() < 2));
      chk("in_ready_b", 32'(in_ready_b), 32'(q.size() < 2));
`ifdef MUX_PIPE_SEL_ERR_EN
      chk("err_cnt_a", 32'(err_cnt_a), 32'd0);
      chk("err_cnt_b", 32'(err_cnt_b), 32'(err_m));
`endif
      if (out_valid_a && q.size() != 0) begin
        chk("out_data_a", out_data_a, q[0].da);
        chk("out_data_b", out_data_b, q[0].db);
        chk("out_sel_a", 32'(out_sel_a), 32'(q[0].sel));
        chk("out_sel_b", 32'(out_sel_b), 32'(q[0].sel));
`ifdef MUX_PIPE_SEL_ERR_EN
        chk("out_sel_err_a", 32'(out_sel_err_a), 32'd0);
        chk("out_sel_err_b", 32'(out_sel_err_b), 32'(q[0].eb));
`endif
        if (out_ready && !flush && !Reset) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [1:0] s, input logic ordy, input logic fl,
                       input logic rst);
    bit   rdy;
    exp_t e;
    in_valid = v; in_sel = s; out_ready = ordy; flush = fl; Reset = rst;
    rdy = (q.size() < 2);
    @(negedge Clk); #1;
    if (rst) begin
      q.delete();
      err_m = 0;
    end else if (fl) begin
      q.delete();
    end else if (v && rdy) begin
      e.da  = w[s];
      e.db  = (s < 2'd3) ? w[s] : 32'h0;
      e.sel = s;
      e.eb  = (s == 2'd3);
      q.push_back(e);
      if (s == 2'd3 && err_m < 255) err_m++;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    Reset = 1'b1; in_valid = 1'b0; in_sel = '0; flush = 1'b0; out_ready = 1'b1;
    @(posedge Clk); #1;
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    mon_en = 1'b1;
    chk("reset out_data_a", out_data_a, 32'h0);
    chk("reset out_sel_a", 32'(out_sel_a), 32'h0);

    // Single transfer, then back-to-back
    cycle(1, 2, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0); cycle(1, 1, 1, 0, 0); cycle(1, 3, 1, 0, 0); cycle(1, 2, 1, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);

    // Stall: fill main and skid, offer a third that must be refused, then drain in order
    cycle(1, 1, 0, 0, 0); cycle(1, 3, 0, 0, 0); cycle(1, 0, 0, 0, 0); cycle(0, 2, 0, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);

    // Out-of-range select on the 3-input instance; err_cnt saturates
    cycle(1, 3, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 299; i++) cycle(1, 3, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);

    // Flush while FULL with an input offered
    cycle(1, 1, 0, 0, 0); cycle(1, 2, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);

    // Reset (with flush) while FULL and stalled
    cycle(1, 3, 0, 0, 0); cycle(1, 2, 0, 0, 0);
    cycle(1, 1, 0, 1, 1);
    chk("midrst out_data_a", out_data_a, 32'h0);
    chk("midrst out_sel_a", 32'(out_sel_a), 32'h0);
    chk("midrst out_data_b", out_data_b, 32'h0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);

    mon_en = 1'b0;
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
